sum_accumulator: RTL and testbench

//   Downstream stage of the 4-bit adder: consumes its 5-bit sum S over a

---
 rtl/sum_accumulator_if.sv | 29 ++
 rtl/sum_accumulator.sv | 93 +++++++++
 tb/tb_sum_accumulator.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder-side producer, the accumulator and the
// result consumer. The accumulator sits on the slave side.
interface sum_accumulator_if #(
  parameter int SUM_W = 5,
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [CNT_W-1:0] out_count;
  logic             overflow;

  modport master (
    output start, num_samples, in_valid, in_sum, out_ready,
    input  in_ready, busy, out_valid, out_total, out_count, overflow
  );

  modport slave (
    input  start, num_samples, in_valid, in_sum, out_ready,
    output in_ready, busy, out_valid, out_total, out_count, overflow
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of adder sums into a wide running total and
// hands the result (total, count, sticky carry) to a consumer.
module sum_accumulator #(
  parameter int SUM_W = 5,
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sum_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last_accept;
  logic [CNT_W-1:0] count_inc;
  logic [ACC_W:0]   sum_ext;

  assign accept      = (state_q == ACCUM) && bus.in_valid;
  assign count_inc   = count_q + CNT_W'(1);
  assign last_accept = accept && (count_inc == target_q);
  // One extra bit captures the carry out of the total for the sticky flag.
  assign sum_ext     = {1'b0, total_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, bus.in_sum};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      count_q  <= '0;
      total_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      total_q  <= total_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = (bus.num_samples == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (last_accept) state_d = DONE;
      end
      DONE: begin
        // start seen together with out_ready is dropped; only IDLE samples it.
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    target_d = target_q;
    count_d  = count_q;
    total_d  = total_q;
    ovf_d    = ovf_q;
    if (state_q == IDLE && bus.start) begin
      target_d = bus.num_samples;
      count_d  = '0;
      total_d  = '0;
      ovf_d    = 1'b0;
    end else if (accept) begin
      count_d  = count_inc;
      total_d  = sum_ext[ACC_W-1:0];
      ovf_d    = ovf_q | sum_ext[ACC_W];
    end
  end

  // Handshake outputs are pure state decodes so nothing ripples from inputs.
  always_comb begin
    bus.in_ready  = (state_q == ACCUM);
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == DONE);
  end

  assign bus.out_total = total_q;
  assign bus.out_count = count_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: table of complete runs plus hand-built
// sequences for gaps, output stall, narrow-total wrap and mid-run reset.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sum_accumulator_if #(.SUM_W(5), .ACC_W(12), .CNT_W(4)) ifa ();
  sum_accumulator_if #(.SUM_W(5), .ACC_W(6),  .CNT_W(4)) ifb ();

  sum_accumulator #(.SUM_W(5), .ACC_W(12), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  sum_accumulator #(.SUM_W(5), .ACC_W(6),  .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  typedef struct packed {
    logic [3:0]       num;
    logic [14:0][4:0] sums;
    logic [11:0]      total;
    logic             ovf;
  } vec_t;

  vec_t vecs [5];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_a(input vec_t v);
    chk("idle_in_ready", ifa.in_ready, 0);
    ifa.start       = 1'b1;
    ifa.num_samples = v.num;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < int'(v.num); i++) begin
      chk("accum_in_ready", ifa.in_ready, 1);
      chk("no_early_valid", ifa.out_valid, 0);
      ifa.in_valid = 1'b1;
      ifa.in_sum   = v.sums[i];
      tick();
    end
    ifa.in_valid = 1'b0;
    chk("done_valid", ifa.out_valid, 1);
    chk("done_total", ifa.out_total, v.total);
    chk("done_count", ifa.out_count, v.num);
    chk("done_ovf", ifa.overflow, v.ovf);
    chk("done_busy", ifa.busy, 1);
    chk("done_in_ready", ifa.in_ready, 0);
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    chk("idle_valid", ifa.out_valid, 0);
    chk("idle_busy", ifa.busy, 0);
    chk("idle_total_kept", ifa.out_total, v.total);
  endtask

  initial begin
    logic [6:0] pat;
    logic [4:0] gsums [4];
    int k;

    rst_n = 1'b0;
    ifa.start = 0; ifa.num_samples = 0; ifa.in_valid = 0; ifa.in_sum = 0; ifa.out_ready = 0;
    ifb.start = 0; ifb.num_samples = 0; ifb.in_valid = 0; ifb.in_sum = 0; ifb.out_ready = 0;

    vecs[0] = '0; vecs[0].num = 3;
    vecs[0].sums[0] = 3; vecs[0].sums[1] = 7; vecs[0].sums[2] = 16;
    vecs[0].total = 26;
    vecs[1] = '0; vecs[1].num = 0; vecs[1].total = 0;
    vecs[2] = '0; vecs[2].num = 1; vecs[2].sums[0] = 31; vecs[2].total = 31;
    vecs[3] = '0; vecs[3].num = 15;
    for (int i = 0; i < 15; i++) vecs[3].sums[i] = 5'd31;
    vecs[3].total = 465;
    vecs[4] = '0; vecs[4].num = 2; vecs[4].total = 0;

    tick(); tick();
    chk("rst_state_busy", ifa.busy, 0);
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_total", ifa.out_total, 0);
    chk("rst_count", ifa.out_count, 0);
    chk("rst_ovf", ifa.overflow, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_a(vecs[i]);

    // valid gaps: only handshaked sums count
    pat = 7'b1011001;  // LSB first: 1,0,0,1,1,0,1
    gsums[0] = 1; gsums[1] = 2; gsums[2] = 3; gsums[3] = 4;
    k = 0;
    ifa.start = 1; ifa.num_samples = 4;
    tick();
    ifa.start = 0;
    for (int c = 0; c < 7; c++) begin
      chk("gap_no_early_valid", ifa.out_valid, 0);
      ifa.in_valid = pat[c];
      ifa.in_sum   = pat[c] ? gsums[k] : 5'd31;
      if (pat[c]) k++;
      tick();
    end
    ifa.in_valid = 0;
    chk("gap_valid", ifa.out_valid, 1);
    chk("gap_total", ifa.out_total, 10);
    chk("gap_count", ifa.out_count, 4);

    // output stall with noise on start/in_valid; start with out_ready not taken
    ifa.out_ready = 1;
    tick();
    ifa.out_ready = 0;
    ifa.start = 1; ifa.num_samples = 2;
    tick();
    ifa.start = 0;
    ifa.in_valid = 1; ifa.in_sum = 5; tick();
    ifa.in_sum = 6; tick();
    ifa.start = 1; ifa.num_samples = 7; ifa.in_sum = 9;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", ifa.out_valid, 1);
      chk("stall_total", ifa.out_total, 11);
      chk("stall_count", ifa.out_count, 2);
      chk("stall_in_ready", ifa.in_ready, 0);
      tick();
    end
    ifa.out_ready = 1;
    tick();
    ifa.out_ready = 0; ifa.start = 0; ifa.in_valid = 0;
    chk("stall_release_valid", ifa.out_valid, 0);
    chk("stall_release_busy", ifa.busy, 0);
    chk("stall_release_total", ifa.out_total, 11);
    tick();
    chk("start_not_taken_busy", ifa.busy, 0);

    // narrow total wraps: 31+31+31 = 93 -> 29 with carry
    ifb.start = 1; ifb.num_samples = 3;
    tick();
    ifb.start = 0;
    ifb.in_valid = 1; ifb.in_sum = 31;
    tick(); tick(); tick();
    ifb.in_valid = 0;
    chk("wrap_valid", ifb.out_valid, 1);
    chk("wrap_total", ifb.out_total, 29);
    chk("wrap_ovf", ifb.overflow, 1);
    chk("wrap_count", ifb.out_count, 3);
    ifb.out_ready = 1;
    tick();
    ifb.out_ready = 0;
    chk("wrap_ovf_sticky_idle", ifb.overflow, 1);

    // reset aborts a run after the second accept
    ifa.start = 1; ifa.num_samples = 5;
    tick();
    ifa.start = 0;
    ifa.in_valid = 1; ifa.in_sum = 2; tick();
    ifa.in_sum = 3; tick();
    ifa.in_valid = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("abort_busy", ifa.busy, 0);
    chk("abort_in_ready", ifa.in_ready, 0);
    chk("abort_valid", ifa.out_valid, 0);
    chk("abort_total", ifa.out_total, 0);
    chk("abort_count", ifa.out_count, 0);
    tick();
    chk("abort_stays_idle", ifa.out_valid, 0);
    vecs[0] = '0; vecs[0].num = 1; vecs[0].sums[0] = 7; vecs[0].total = 7;
    run_a(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
